// File: rtl/truth_table_sequencer.sv
// Stimulus/capture sequencer for a 3-input combinational function: walks the eight
// {a,b,c} patterns, samples o after each dwell, and grades the captured truth table.
module truth_table_sequencer #(
    parameter int DWELL = 10,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       o,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       pass,
    output logic [7:0] mismatch
);

    generate
        if ((DWELL < 1) || (DWELL > ((1 << CNT_W) - 1))) begin : g_bad_dwell
            $error("truth_table_sequencer: DWELL must be in 1..2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Drive order deliberately differs from binary count so an output stuck to one input shows up.
    function automatic logic [2:0] pattern_of(input logic [2:0] idx);
        logic [2:0] p;
        case (idx)
            3'd0:    p = 3'b000;
            3'd1:    p = 3'b100;
            3'd2:    p = 3'b010;
            3'd3:    p = 3'b011;
            3'd4:    p = 3'b001;
            3'd5:    p = 3'b110;
            3'd6:    p = 3'b101;
            3'd7:    p = 3'b111;
            default: p = 3'b000;
        endcase
        return p;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       abc_q, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       tt_q, tt_d;
    logic             pass_q, pass_d;
    logic [7:0]       mism_q, mism_d;
    logic [7:0]       exp_q, exp_d;
    logic [7:0]       tt_smp_s;

    // Table with the currently driven pattern's o folded in.
    always_comb begin
        tt_smp_s        = tt_q;
        tt_smp_s[abc_q] = o;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tt_d    = tt_q;
        pass_d  = pass_q;
        mism_d  = mism_q;
        exp_d   = exp_q;
        case (state_q)
            S_IDLE: begin
                abc_d  = 3'b000;
                busy_d = 1'b0;
                if (start) begin
                    exp_d   = expected;
                    tt_d    = 8'h00;
                    pass_d  = 1'b0;
                    mism_d  = 8'h00;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    abc_d   = pattern_of(3'd0);
                    busy_d  = 1'b1;
                    state_d = S_APPLY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_APPLY: begin
                if (cnt_q == DWELL_M1) begin
                    tt_d  = tt_smp_s;
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        // Grade from the completed table so results line up with done.
                        idx_d   = 3'd0;
                        abc_d   = 3'b000;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (tt_smp_s == exp_q);
                        mism_d  = tt_smp_s ^ exp_q;
                        state_d = S_FINISH;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        abc_d = pattern_of(idx_q + 3'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                abc_d   = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            abc_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= 8'h00;
            pass_q  <= 1'b0;
            mism_q  <= 8'h00;
            exp_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
            mism_q  <= mism_d;
            exp_q   <= exp_d;
        end
    end

    assign a           = abc_q[2];
    assign b           = abc_q[1];
    assign c           = abc_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign pass        = pass_q;
    assign mismatch    = mism_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: three sequencers (majority/DWELL=10, pass-through/DWELL=3, XOR/DWELL=1).
module tb_truth_table_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_s    [3];
    logic [7:0] expected_s [3];
    logic       o_s        [3];
    logic       a_s        [3];
    logic       b_s        [3];
    logic       c_s        [3];
    logic       busy_s     [3];
    logic       done_s     [3];
    logic [7:0] tt_s       [3];
    logic       pass_s     [3];
    logic [7:0] mism_s     [3];

    int n_cmp;
    int n_bad;

    truth_table_sequencer #(.DWELL(10), .CNT_W(8)) u_maj (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .expected(expected_s[0]), .o(o_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .truth_table(tt_s[0]), .pass(pass_s[0]), .mismatch(mism_s[0]));

    truth_table_sequencer #(.DWELL(3), .CNT_W(8)) u_pth (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .expected(expected_s[1]), .o(o_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .truth_table(tt_s[1]), .pass(pass_s[1]), .mismatch(mism_s[1]));

    truth_table_sequencer #(.DWELL(1), .CNT_W(8)) u_xor (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .expected(expected_s[2]), .o(o_s[2]),
        .a(a_s[2]), .b(b_s[2]), .c(c_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .truth_table(tt_s[2]), .pass(pass_s[2]), .mismatch(mism_s[2]));

    assign o_s[0] = (a_s[0] & b_s[0]) | (a_s[0] & c_s[0]) | (b_s[0] & c_s[0]);
    assign o_s[1] = a_s[1];
    assign o_s[2] = a_s[2] ^ b_s[2] ^ c_s[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start unit u with expected e; lat = edges from acceptance to done (-1 on timeout).
    task automatic run_unit(input int u, input logic [7:0] e, output int lat, output int bcnt);
        expected_s[u] = e;
        start_s[u] = 1'b1;
        tick();
        start_s[u] = 1'b0;
        bcnt = busy_s[u] ? 1 : 0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (busy_s[u]) bcnt++;
            if (done_s[u]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [22:0] v;
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            start_s[u] = 1'b0;
            expected_s[u] = 8'h00;
        end
        #12;
        for (int u = 0; u < 3; u++) begin
            v = {a_s[u], b_s[u], c_s[u], busy_s[u], done_s[u], tt_s[u], pass_s[u], mism_s[u], 2'b00};
            n_cmp++;
            if (v !== 23'd0) begin
                n_bad++;
                $display("FAIL reset_outputs unit %0d got %h want 0", u, v);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_majority_pass();
        int lat, bcnt;
        run_unit(0, 8'hE8, lat, bcnt);
        n_cmp++; if (lat !== 80) begin n_bad++; $display("FAIL t1_latency got %0d want 80", lat); end
        n_cmp++; if (bcnt !== 80) begin n_bad++; $display("FAIL t1_busy_cycles got %0d want 80", bcnt); end
        n_cmp++; if (tt_s[0] !== 8'hE8) begin n_bad++; $display("FAIL t1_table got %h want e8", tt_s[0]); end
        n_cmp++; if (pass_s[0] !== 1'b1) begin n_bad++; $display("FAIL t1_pass got %b want 1", pass_s[0]); end
        n_cmp++; if (mism_s[0] !== 8'h00) begin n_bad++; $display("FAIL t1_mismatch got %h want 00", mism_s[0]); end
        tick();
        n_cmp++; if (done_s[0] !== 1'b0) begin n_bad++; $display("FAIL t1_done_width got %b want 0", done_s[0]); end
        n_cmp++; if (pass_s[0] !== 1'b1) begin n_bad++; $display("FAIL t1_pass_hold got %b want 1", pass_s[0]); end
    endtask

    task automatic test_majority_fail_then_pass();
        int lat, bcnt;
        tick();
        run_unit(0, 8'hE9, lat, bcnt);
        n_cmp++; if (tt_s[0] !== 8'hE8) begin n_bad++; $display("FAIL t2_table got %h want e8", tt_s[0]); end
        n_cmp++; if (pass_s[0] !== 1'b0) begin n_bad++; $display("FAIL t2_pass got %b want 0", pass_s[0]); end
        n_cmp++; if (mism_s[0] !== 8'h01) begin n_bad++; $display("FAIL t2_mismatch got %h want 01", mism_s[0]); end
        tick();
        tick();
        // Second run: results must be cleared at acceptance.
        expected_s[0] = 8'hE8;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        n_cmp++; if (pass_s[0] !== 1'b0) begin n_bad++; $display("FAIL t2_pass_cleared got %b want 0", pass_s[0]); end
        n_cmp++; if (mism_s[0] !== 8'h00) begin n_bad++; $display("FAIL t2_mism_cleared got %h want 00", mism_s[0]); end
        n_cmp++; if (tt_s[0] !== 8'h00) begin n_bad++; $display("FAIL t2_table_cleared got %h want 00", tt_s[0]); end
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (done_s[0]) begin lat = n; break; end
        end
        n_cmp++; if (lat !== 80) begin n_bad++; $display("FAIL t2_latency got %0d want 80", lat); end
        n_cmp++; if (pass_s[0] !== 1'b1) begin n_bad++; $display("FAIL t2_second_pass got %b want 1", pass_s[0]); end
        tick();
    endtask

    task automatic test_pattern_order();
        logic [2:0] pat [8];
        logic [2:0] got;
        pat[0] = 3'b000; pat[1] = 3'b100; pat[2] = 3'b010; pat[3] = 3'b011;
        pat[4] = 3'b001; pat[5] = 3'b110; pat[6] = 3'b101; pat[7] = 3'b111;
        expected_s[1] = 8'hF0;
        start_s[1] = 1'b1;
        tick();
        start_s[1] = 1'b0;
        for (int j = 0; j < 24; j++) begin
            got = {a_s[1], b_s[1], c_s[1]};
            n_cmp++;
            if (got !== pat[j / 3]) begin
                n_bad++;
                $display("FAIL t3_abc cycle %0d got %b want %b", j, got, pat[j / 3]);
            end
            n_cmp++;
            if (done_s[1] !== 1'b0) begin n_bad++; $display("FAIL t3_early_done cycle %0d got 1 want 0", j); end
            tick();
        end
        got = {a_s[1], b_s[1], c_s[1]};
        n_cmp++; if (done_s[1] !== 1'b1) begin n_bad++; $display("FAIL t3_done got %b want 1", done_s[1]); end
        n_cmp++; if (got !== 3'b000) begin n_bad++; $display("FAIL t3_abc_finish got %b want 000", got); end
        n_cmp++; if (tt_s[1] !== 8'hF0) begin n_bad++; $display("FAIL t3_table got %h want f0", tt_s[1]); end
        n_cmp++; if (pass_s[1] !== 1'b1) begin n_bad++; $display("FAIL t3_pass got %b want 1", pass_s[1]); end
        tick();
    endtask

    task automatic test_start_ignored();
        int done_at, done_cnt;
        done_at = -1;
        done_cnt = 0;
        expected_s[0] = 8'hE8;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        expected_s[0] = 8'h00;
        for (int n = 1; n <= 180; n++) begin
            start_s[0] = ((n == 5) || (n == 40) || (n == done_at + 1)) ? 1'b1 : 1'b0;
            tick();
            if (done_s[0]) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
        end
        start_s[0] = 1'b0;
        n_cmp++; if (done_at !== 80) begin n_bad++; $display("FAIL t4_done_edge got %0d want 80", done_at); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL t4_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (tt_s[0] !== 8'hE8) begin n_bad++; $display("FAIL t4_table got %h want e8", tt_s[0]); end
        n_cmp++; if (pass_s[0] !== 1'b1) begin n_bad++; $display("FAIL t4_pass got %b want 1", pass_s[0]); end
        n_cmp++; if (busy_s[0] !== 1'b0) begin n_bad++; $display("FAIL t4_busy_after got %b want 0", busy_s[0]); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt, done_cnt;
        logic [22:0] v;
        expected_s[0] = 8'hE8;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        for (int n = 1; n <= 37; n++) tick();
        rst_n = 1'b0;
        #2;
        v = {a_s[0], b_s[0], c_s[0], busy_s[0], done_s[0], tt_s[0], pass_s[0], mism_s[0], 2'b00};
        n_cmp++; if (v !== 23'd0) begin n_bad++; $display("FAIL t5_reset_outputs got %h want 0", v); end
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (done_s[0] || busy_s[0]) done_cnt++;
        end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL t5_no_resume got %0d want 0", done_cnt); end
        run_unit(0, 8'hE8, lat, bcnt);
        n_cmp++; if (lat !== 80) begin n_bad++; $display("FAIL t5_latency got %0d want 80", lat); end
        n_cmp++; if (tt_s[0] !== 8'hE8) begin n_bad++; $display("FAIL t5_table got %h want e8", tt_s[0]); end
        n_cmp++; if (pass_s[0] !== 1'b1) begin n_bad++; $display("FAIL t5_pass got %b want 1", pass_s[0]); end
        tick();
    endtask

    task automatic test_dwell_one();
        int lat, bcnt;
        run_unit(2, 8'h96, lat, bcnt);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL t6_latency got %0d want 8", lat); end
        n_cmp++; if (bcnt !== 8) begin n_bad++; $display("FAIL t6_busy_cycles got %0d want 8", bcnt); end
        n_cmp++; if (tt_s[2] !== 8'h96) begin n_bad++; $display("FAIL t6_table got %h want 96", tt_s[2]); end
        n_cmp++; if (pass_s[2] !== 1'b1) begin n_bad++; $display("FAIL t6_pass got %b want 1", pass_s[2]); end
        n_cmp++; if (mism_s[2] !== 8'h00) begin n_bad++; $display("FAIL t6_mismatch got %h want 00", mism_s[2]); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_majority_pass();
        test_majority_fail_then_pass();
        test_pattern_order();
        test_start_ignored();
        test_reset_mid_run();
        test_dwell_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Upstream stimulus and capture stage for the 3-input combinational lab functions (inputs a, b, c; output o). On a start request it drives the eight input combinations in a fixed order, holding each one for DWELL cycles. It samples the function output o at the end of each dwell and assembles an 8-bit truth table. It then compares the table against an expected table and reports pass/fail with a done pulse.

Parameters:
DWELL, 10, cycles each input pattern is held; legal range 1..2^CNT_W-1
CNT_W, 8, width of the dwell counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request; accepted only in IDLE
expected  input  8  expected truth table; bit index = {a,b,c}
o  input  1  output of the function under drive (combinational, same clock domain)
a  output  1  stimulus MSB
b  output  1  stimulus
c  output  1  stimulus LSB
busy  output  1  high while patterns are being applied
done  output  1  single-cycle pulse; table, pass and mismatch are valid
truth_table  output  8  captured o values; bit {a,b,c}
pass  output  1  truth_table == latched expected; held until the next accepted start
mismatch  output  8  truth_table XOR latched expected; held like pass

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE, a=b=c=0, busy=0, done=0, truth_table=0, pass=0, mismatch=0, pattern index=0, dwell counter=0, expected latch=0.
- Pattern order, index 0..7, as {a,b,c}: 000, 100, 010, 011, 001, 110, 101, 111. Implement as a registered lookup.
- States: IDLE, APPLY, FINISH.
- IDLE:
  - abc=000, busy=0.
  - On the edge E0 where start=1:
    - latch expected
    - clear truth_table, pass and mismatch to 0
    - set index=0, count=0, abc=pattern 0, busy=1
    - go to APPLY.
- APPLY:
  - count increments every cycle.
  - On an edge where count==DWELL-1:
    - sample o into truth_table[{a,b,c}] using the currently driven abc
    - if index==7: go to FINISH with abc=000 and busy=0
    - otherwise: index+1, drive the next pattern, count=0.
  - Pattern k is driven from edge E0+k*DWELL until E0+(k+1)*DWELL. o is sampled at edge E0+(k+1)*DWELL.
- FINISH:
  - Entered at edge E0+8*DWELL. done=1 for exactly this one cycle.
  - pass and mismatch are computed from the final table, registered, and visible in the same cycle as done.
  - At the next edge: done=0, go to IDLE.
- Latency: start accepted to done high is 8*DWELL edges. busy is high for exactly 8*DWELL cycles.
- start while in APPLY or FINISH is ignored. It is not queued, and neither expected nor the run is disturbed.
- Changes on expected after acceptance have no effect until the next accepted start.
- DWELL=1: each pattern lasts one cycle. o must settle combinationally within that cycle.
- rst_n asserted mid-run: everything returns to reset values immediately. No done pulse is produced for the aborted run.
- Counter wrap is not possible: count never exceeds DWELL-1. A DWELL of 0 or a DWELL that overflows CNT_W is illegal; flag it with an elaboration-time check.

Test Plan:
1. o driven by 3-input majority, DWELL=10, expected=8'hE8, start pulse -> busy high for 80 cycles; done at edge 80 after acceptance; truth_table=8'hE8, pass=1, mismatch=8'h00.
2. Same DUT, expected=8'hE9 -> truth_table=8'hE8, pass=0, mismatch=8'h01. Then a second run with expected=8'hE8 -> pass=1; pass and mismatch cleared to 0 at the second acceptance.
3. Pattern-order check, o=a (pass-through), DWELL=3 -> abc sequence 000,100,010,011,001,110,101,111, each held exactly 3 cycles; truth_table=8'hF0.
4. start re-pulsed at cycles 5 and 40 of a run, and again during the FINISH cycle -> no restart, a single done, results unchanged; done never high for more than one cycle.
5. rst_n low at cycle 37 of a run, then released, then start -> all outputs read 0 during reset; the fresh run completes normally with the correct table.
6. DWELL=1, o=a XOR b XOR c, expected=8'h96 -> done 8 edges after acceptance, pass=1.
